// File: rtl/data_memory_mp.sv
// data_memory_mp: multi-port byte-addressed data memory for the MEM stage.
// NUM_LD independent load ports plus one byte/halfword/word store port over a
// shared RAM. Loads are RV32I sign/zero-extended and registered (latency 1),
// with per-port valid and error flags; illegal stores raise a one-cycle st_err.
// Optional macro DATA_MEMORY_MP_BYPASS_EN: forward a legal same-edge store
// into loads of the same word (merged bytes). Undefined = read-first.
module data_memory_mp #(
  parameter int ADDR_W = 10,
  parameter int NUM_LD = 2,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LD-1:0]          ld_valid,
  input  logic [NUM_LD*ADDR_W-1:0]   ld_addr,
  input  logic [NUM_LD*3-1:0]        ld_funct3,
  output logic [NUM_LD*DATA_W-1:0]   ld_rdata,
  output logic [NUM_LD-1:0]          ld_rvalid,
  output logic [NUM_LD-1:0]          ld_err,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [2:0]                 st_funct3,
  input  logic [DATA_W-1:0]          st_wdata,
  output logic                       st_err
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WORD_W;
  localparam int NBYTES = DATA_W / 8;

  // Load legality: halfwords need even offset, words need offset 00,
  // and funct3 011/110/111 are not loads.
  function automatic logic ld_is_legal(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = ~off[0];
      3'b010:         ok = (off == 2'b00);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Select the addressed byte/halfword and extend it to a full word.
  function automatic logic [DATA_W-1:0] ld_extract(input logic [DATA_W-1:0] word,
                                                   input logic [2:0]        f3,
                                                   input logic [1:0]        off);
    logic        [DATA_W-1:0] sh;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic        [DATA_W-1:0] res;
    sh = word >> {off, 3'b000};
    b  = $signed(sh[7:0]);
    h  = $signed(sh[15:0]);
    case (f3)
      3'b000:  res = {{(DATA_W-8){b[7]}}, b};
      3'b001:  res = {{(DATA_W-16){h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {{(DATA_W-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]              st_off;
  logic [WORD_W-1:0]       st_idx;
  logic [NBYTES-1:0]       st_mask;
  logic                    st_legal;
  logic [DATA_W-1:0]       st_lane;
  logic                    st_we;

  logic [NUM_LD-1:0][DATA_W-1:0] ld_word;
  logic [NUM_LD-1:0][DATA_W-1:0] rdata_d;
  logic [NUM_LD-1:0]             err_d;

  logic [NUM_LD-1:0][DATA_W-1:0] rdata_q;
  logic [NUM_LD-1:0]             rvalid_q;
  logic [NUM_LD-1:0]             err_q;
  logic                          st_err_q;
  logic                          st_err_d;

  // Store decode: byte-lane mask, legality, and data shifted into its lane.
  always_comb begin
    st_off   = st_addr[1:0];
    st_idx   = st_addr[ADDR_W-1:2];
    st_mask  = '0;
    st_legal = 1'b0;
    case (st_funct3)
      3'b000: begin
        st_mask  = 4'b0001 << st_off;
        st_legal = 1'b1;
      end
      3'b001: begin
        st_mask  = 4'b0011 << st_off;
        st_legal = ~st_off[0];
      end
      3'b010: begin
        st_mask  = 4'b1111;
        st_legal = (st_off == 2'b00);
      end
      default: begin
        st_mask  = '0;
        st_legal = 1'b0;
      end
    endcase
    if (!st_legal) st_mask = '0;
    st_lane  = st_wdata << {st_off, 3'b000};
    st_we    = st_valid & st_legal & ~rst;
    st_err_d = st_valid & ~st_legal;
  end

  // RAM write: only masked bytes change; contents survive reset.
  always_ff @(posedge clk) begin
    if (st_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (st_mask[b]) mem_q[st_idx][b*8 +: 8] <= st_lane[b*8 +: 8];
      end
    end
  end

  // Per-port read: RAM word (optionally merged with the same-edge store),
  // then extraction and legality.
  always_comb begin
    ld_word = '0;
    rdata_d = '0;
    err_d   = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      ld_word[i] = mem_q[ld_addr[i*ADDR_W+2 +: WORD_W]];
`ifdef DATA_MEMORY_MP_BYPASS_EN
      if (st_valid && st_legal && (ld_addr[i*ADDR_W+2 +: WORD_W] == st_idx)) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (st_mask[b]) ld_word[i][b*8 +: 8] = st_lane[b*8 +: 8];
        end
      end
`endif
      if (ld_is_legal(ld_funct3[i*3 +: 3], ld_addr[i*ADDR_W +: 2])) begin
        rdata_d[i] = ld_extract(ld_word[i], ld_funct3[i*3 +: 3], ld_addr[i*ADDR_W +: 2]);
        err_d[i]   = 1'b0;
      end else begin
        rdata_d[i] = '0;
        err_d[i]   = 1'b1;
      end
    end
  end

  // Result registers: rvalid follows the request; data/err hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      st_err_q <= 1'b0;
    end else begin
      rvalid_q <= ld_valid;
      st_err_q <= st_err_d;
      for (int i = 0; i < NUM_LD; i++) begin
        if (ld_valid[i]) begin
          rdata_q[i] <= rdata_d[i];
          err_q[i]   <= err_d[i];
        end
      end
    end
  end

  assign ld_rdata  = rdata_q;
  assign ld_rvalid = rvalid_q;
  assign ld_err    = err_q;
  assign st_err    = st_err_q;

endmodule

// File: tb/tb_data_memory_mp.sv
module tb_data_memory_mp;
  localparam int ADDR_W = 10;
  localparam int NUM_LD = 2;
  localparam int DATA_W = 32;

  logic                      clk;
  logic                      rst;
  logic [NUM_LD-1:0]         ld_valid;
  logic [NUM_LD*ADDR_W-1:0]  ld_addr;
  logic [NUM_LD*3-1:0]       ld_funct3;
  logic [NUM_LD*DATA_W-1:0]  ld_rdata;
  logic [NUM_LD-1:0]         ld_rvalid;
  logic [NUM_LD-1:0]         ld_err;
  logic                      st_valid;
  logic [ADDR_W-1:0]         st_addr;
  logic [2:0]                st_funct3;
  logic [DATA_W-1:0]         st_wdata;
  logic                      st_err;

  int tests;
  int fails;

  data_memory_mp #(.ADDR_W(ADDR_W), .NUM_LD(NUM_LD), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_funct3 (ld_funct3),
    .ld_rdata  (ld_rdata),
    .ld_rvalid (ld_rvalid),
    .ld_err    (ld_err),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_funct3 (st_funct3),
    .st_wdata  (st_wdata),
    .st_err    (st_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ld(input int p, input logic v, input logic [ADDR_W-1:0] a, input logic [2:0] f);
    ld_valid[p]                 = v;
    ld_addr[p*ADDR_W +: ADDR_W] = a;
    ld_funct3[p*3 +: 3]         = f;
  endtask

  task automatic set_st(input logic v, input logic [ADDR_W-1:0] a, input logic [2:0] f, input logic [31:0] d);
    st_valid  = v;
    st_addr   = a;
    st_funct3 = f;
    st_wdata  = d;
  endtask

  task automatic idle();
    ld_valid = '0;
    st_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    ld_valid = '0; ld_addr = '0; ld_funct3 = '0;
    set_st(1'b0, '0, 3'b000, 32'h0);

    // Reset for two cycles, then one idle cycle.
    cyc(); cyc();
    check("rst_rvalid", {30'h0, ld_rvalid}, 32'h0);
    check("rst_st_err", {31'h0, st_err}, 32'h0);
    check("rst_ld_err", {30'h0, ld_err}, 32'h0);
    rst = 1'b0;
    cyc();
    check("idle_rvalid", {30'h0, ld_rvalid}, 32'h0);
    check("idle_st_err", {31'h0, st_err}, 32'h0);
    check("idle_rdata0", ld_rdata[31:0], 32'h0);
    check("idle_rdata1", ld_rdata[63:32], 32'h0);

    // SW then LB / LBU on two ports.
    set_st(1'b1, 10'h010, 3'b010, 32'h8000_12F0);
    cyc();
    check("sw_st_err", {31'h0, st_err}, 32'h0);
    idle();
    set_ld(0, 1'b1, 10'h010, 3'b000);
    set_ld(1, 1'b1, 10'h011, 3'b100);
    cyc();
    check("lb_lbu_rvalid", {30'h0, ld_rvalid}, 32'h3);
    check("lb_rdata0", ld_rdata[31:0], 32'hFFFF_FFF0);
    check("lbu_rdata1", ld_rdata[63:32], 32'h0000_0012);
    check("lb_lbu_err", {30'h0, ld_err}, 32'h0);
    idle();
    cyc();
    check("hold_rvalid", {30'h0, ld_rvalid}, 32'h0);
    check("hold_rdata0", ld_rdata[31:0], 32'hFFFF_FFF0);

    // SB into top byte, then LW / LH / LHU.
    set_st(1'b1, 10'h013, 3'b000, 32'h0000_00AA);
    cyc();
    idle();
    set_ld(0, 1'b1, 10'h010, 3'b010);
    set_ld(1, 1'b1, 10'h012, 3'b001);
    cyc();
    check("sb_lw_rdata0", ld_rdata[31:0], 32'hAA00_12F0);
    check("lh_rdata1", ld_rdata[63:32], 32'hFFFF_AA00);
    set_ld(0, 1'b1, 10'h012, 3'b101);
    set_ld(1, 1'b1, 10'h010, 3'b010);
    cyc();
    check("lhu_rdata0", ld_rdata[31:0], 32'h0000_AA00);
    check("same_word_rdata1", ld_rdata[63:32], 32'hAA00_12F0);

    // Misaligned / illegal stores and loads.
    idle();
    set_st(1'b1, 10'h020, 3'b010, 32'hCAFE_BABE);
    cyc();
    set_st(1'b1, 10'h021, 3'b001, 32'h0000_1234);
    cyc();
    check("sh_mis_st_err", {31'h0, st_err}, 32'h1);
    set_st(1'b1, 10'h020, 3'b011, 32'h0000_0000);
    cyc();
    check("st_f3_011_err", {31'h0, st_err}, 32'h1);
    idle();
    cyc();
    check("st_err_pulse", {31'h0, st_err}, 32'h0);
    set_ld(0, 1'b1, 10'h020, 3'b010);
    set_ld(1, 1'b1, 10'h022, 3'b010);
    cyc();
    check("mis_unchanged0", ld_rdata[31:0], 32'hCAFE_BABE);
    check("lw_mis_rdata1", ld_rdata[63:32], 32'h0);
    check("lw_mis_err", {30'h0, ld_err}, 32'h2);
    check("lw_mis_rvalid", {30'h0, ld_rvalid}, 32'h3);
    set_ld(0, 1'b1, 10'h020, 3'b011);
    set_ld(1, 1'b1, 10'h020, 3'b010);
    cyc();
    check("ld_f3_011_err", {30'h0, ld_err}, 32'h1);
    check("ld_f3_011_rdata0", ld_rdata[31:0], 32'h0);
    check("ld_f3_011_rdata1", ld_rdata[63:32], 32'hCAFE_BABE);
    set_ld(0, 1'b1, 10'h020, 3'b100);
    ld_valid[1] = 1'b0;
    cyc();
    check("err_clear", {30'h0, ld_err}, 32'h0);
    check("lbu_be", ld_rdata[31:0], 32'h0000_00BE);

    // Same-edge store and load to one word.
    idle();
    set_st(1'b1, 10'h040, 3'b010, 32'h0000_0000);
    cyc();
    set_st(1'b1, 10'h040, 3'b010, 32'h1234_5678);
    set_ld(0, 1'b1, 10'h040, 3'b010);
    cyc();
`ifdef DATA_MEMORY_MP_BYPASS_EN
    check("rdw_same_edge", ld_rdata[31:0], 32'h1234_5678);
`else
    check("rdw_same_edge", ld_rdata[31:0], 32'h0000_0000);
`endif
    st_valid = 1'b0;
    cyc();
    check("rdw_next", ld_rdata[31:0], 32'h1234_5678);

    // Reset during requests.
    idle();
    set_st(1'b1, 10'h050, 3'b010, 32'h0BAD_F00D);
    cyc();
    rst = 1'b1;
    set_st(1'b1, 10'h050, 3'b010, 32'hDEAD_BEEF);
    set_ld(0, 1'b1, 10'h010, 3'b010);
    cyc();
    check("rst_mid_rvalid", {30'h0, ld_rvalid}, 32'h0);
    check("rst_mid_rdata0", ld_rdata[31:0], 32'h0);
    rst = 1'b0;
    idle();
    cyc();
    set_ld(0, 1'b1, 10'h050, 3'b010);
    cyc();
    check("rst_no_write", ld_rdata[31:0], 32'h0BAD_F00D);
    check("rst_after_rvalid", {30'h0, ld_rvalid}, 32'h1);
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory_mp.md
Name: data_memory_mp

Overview:
- Parametrised successor of the single-port word-only data memory, for the superscalar core's MEM stage.
- Provides NUM_LD independent load ports and one store port over a shared byte-addressed RAM.
- Stores use byte/halfword/word lanes. Loads are sign- or zero-extended per RV32I funct3.
- Read data is registered: one-cycle load latency, with valid and error flags.

Parameters:
- ADDR_W, 10, byte-address width; RAM depth = 2**(ADDR_W-2) words.
- NUM_LD, 2, number of load ports (1..4).
- DATA_W, 32, word width; fixed at 32, parametrised for lint only.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ld_valid  in  NUM_LD  per-port load request.
- ld_addr  in  NUM_LD*ADDR_W  byte addresses, port i at [i*ADDR_W +: ADDR_W].
- ld_funct3  in  NUM_LD*3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ld_rdata  out  NUM_LD*32  extended load result, registered.
- ld_rvalid  out  NUM_LD  result valid, one cycle after the request.
- ld_err  out  NUM_LD  misaligned or illegal-funct3 load, registered.
- st_valid  in  1  store request.
- st_addr  in  ADDR_W  store byte address.
- st_funct3  in  3  store type: 000 SB, 001 SH, 010 SW.
- st_wdata  in  32  store data, LSB-aligned; the block shifts it into the lane.
- st_err  out  1  misaligned or illegal store, registered one-cycle pulse.

Behaviour:
- Reset (rst=1 at an edge): ld_rdata=0, ld_rvalid=0, ld_err=0, st_err=0. RAM contents are not cleared. Requests presented in a reset cycle are discarded: no write, no rvalid the next cycle.
- Word index = addr[ADDR_W-1:2]. Byte offset = addr[1:0].
- Store byte mask: SB = 1<<off. SH = 0011<<off, legal only if off[0]=0. SW = 1111, legal only if off=00.
- st_valid with a legal store writes only the masked bytes at the edge; other bytes are unchanged.
- An illegal store (misaligned or funct3 not in {000,001,010}) performs no write; st_err=1 in the next cycle only.
- Load, latency 1: ld_valid[i] at edge N -> ld_rvalid[i]=1 and ld_rdata[i] valid after edge N, held until edge N+1. ld_rvalid[i]=0 in any cycle following no request.
- Load extraction: select the byte/halfword at the offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Illegal load (LH/LHU with off[0]=1, LW with off!=00, funct3 in {011,110,111}): ld_rvalid=1, ld_err=1, ld_rdata=0.
- ld_err is cleared the cycle after any non-error result.
- ld_rdata and ld_err hold their previous values when ld_valid=0; only ld_rvalid drops.
- Multiple load ports may address the same word in one cycle; each returns an independent, correct result.
- Read-during-write, same word, same edge, without bypass: the load returns pre-store (old) data.
- Write-then-read on a later edge always returns the new data.
- No back-pressure: every request is accepted every cycle.

Optional Feature:
- Macro DATA_MEMORY_MP_BYPASS_EN.
- Defined: a load and a legal store to the same word at the same edge return merged data. Bytes in the store mask come from the shifted st_wdata; the remaining bytes come from the RAM. The result is then extended per ld_funct3.
- Undefined: read-first behaviour as above, and no forwarding logic is instantiated.
- Illegal stores are never forwarded, in either mode.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release with no requests -> ld_rvalid=00, st_err=0, ld_rdata=0 on all ports.
- Store SW 0x8000_12F0 @0x010, then next cycle LB @0x010 and LBU @0x011 on ports 0/1 -> ld_rdata0=0xFFFF_FFF0, ld_rdata1=0x0000_0012, both rvalid=1 one cycle later.
- SB 0xAA @0x013 over 0x8000_12F0, then LW @0x010 -> 0xAA00_12F0. Then LH @0x012 -> 0xFFFF_AA00, LHU @0x012 -> 0x0000_AA00.
- Misaligned: SH @0x021 -> st_err=1 for exactly one cycle and word 0x020 unchanged. LW @0x022 -> rvalid=1, err=1, rdata=0. funct3=011 load -> err=1.
- Same-edge SW 0x1234_5678 @0x040 (old value 0) and LW @0x040 -> 0x0000_0000 without the macro, 0x1234_5678 with it. The next-cycle LW returns 0x1234_5678 in both builds.
- Reset mid-operation: LW @0x010 and SW @0x050 presented with rst=1 -> no rvalid the next cycle, and a later LW @0x050 returns its prior contents.
